hash_engine_arbiter: RTL and testbench

- Shares one pearson_hash8 engine between N_REQ requesters, e.g. key verification, wallet address generation and block mining.
- Picks one requester at a time using round-robin priority, and latches that requester's 8-bit message.
- Clears the engine, then holds it enabled until it reports finished.
- Returns the 8-bit hash to the winning requester with a one-cycle response strobe. A watchdog aborts a job if the engine stalls.

---
 rtl/hash_arb_pkg.sv | 11 +
 rtl/hash_engine_arbiter_rr_pick.sv | 29 ++
 rtl/hash_engine_arbiter.sv | 93 +++++++++
 tb/tb_hash_engine_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/hash_arb_pkg.sv
// hash_arb_pkg: shared constants for the hash engine arbiter
//   FSM state encodings, message/hash widths and the value returned on timeout.
package hash_arb_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam int MSG_W  = 8;
    localparam int HASH_W = 8;
    localparam logic [HASH_W-1:0] TIMEOUT_HASH = 8'h00;
endpackage

// File: rtl/hash_engine_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker
//   req : request vector       ptr : index searched first
//   gnt : one-hot winner       idx : encoded winner      any : any request present
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             any
);
    logic [PTR_W:0] j;
    always_comb begin
        j   = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = {1'b0, ptr} + (PTR_W+1)'(k);
            j = (j >= (PTR_W+1)'(N)) ? j - (PTR_W+1)'(N) : j;
            if (!any && req[j[PTR_W-1:0]]) begin
                any = 1'b1;
                idx = j[PTR_W-1:0];
            end
        end
    end
    assign gnt = any ? (N'(1) << idx) : '0;
endmodule

// File: rtl/hash_engine_arbiter.sv
// hash_engine_arbiter: round-robin sharing of one pearson_hash8 engine
//   clock, reset             : clock and async active-high reset
//   req, req_msg             : per-requester level request and message byte
//   grant                    : one-hot current engine owner
//   resp_valid/hash/err      : one-cycle result strobe, hash and timeout flag
//   busy                     : any state other than IDLE
//   hash_message/enable/reset_n, hash_result/finished : engine interface
module hash_engine_arbiter
    import hash_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [MSG_W*N_REQ-1:0] req_msg,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       resp_valid,
    output logic [HASH_W-1:0]      resp_hash,
    output logic                   resp_err,
    output logic                   busy,
    output logic [MSG_W-1:0]       hash_message,
    output logic                   hash_enable,
    output logic                   hash_reset_n,
    input  logic [HASH_W-1:0]      hash_result,
    input  logic                   hash_finished
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int PTR_W = $clog2(N_REQ);
    logic [1:0]       state;
    logic [PTR_W-1:0] rr_ptr, idx_q, pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;
    logic [CNT_W-1:0] cnt;
    logic [MSG_W-1:0] msg_q;
    rr_pick #(.N(N_REQ)) u_pick (
        .req(req),
        .ptr(rr_ptr),
        .gnt(pick_gnt),
        .idx(pick_idx),
        .any(pick_any)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            idx_q     <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            msg_q     <= '0;
            resp_hash <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_any) begin
                    grant <= pick_gnt;
                    idx_q <= pick_idx;
                    msg_q <= req_msg[pick_idx*MSG_W +: MSG_W];
                    state <= CLEAR;
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    // finished takes precedence over a coinciding timeout
                    if (hash_finished) begin
                        resp_hash <= hash_result;
                        resp_err  <= 1'b0;
                        state     <= DONE;
                    end else if (cnt == CNT_W'(TIMEOUT-1)) begin
                        resp_hash <= TIMEOUT_HASH;
                        resp_err  <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    grant  <= '0;
                    rr_ptr <= (idx_q == PTR_W'(N_REQ-1)) ? '0 : idx_q + 1'b1;
                    state  <= IDLE;
                end
            endcase
        end
    end
    assign resp_valid   = (state == DONE) ? grant : '0;
    assign busy         = state != IDLE;
    assign hash_message = msg_q;
    assign hash_enable  = state == RUN;
    // engine is held in reset during CLEAR and for as long as our own reset is high
    assign hash_reset_n = ~reset & (state != CLEAR);
endmodule

// File: tb/tb_hash_engine_arbiter.sv
// tb_hash_engine_arbiter: randomized and directed checks against a job-timeline model
module tb_hash_engine_arbiter;
    localparam int N = 4;
    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [8*N-1:0] req_msg = '0;
    logic [N-1:0] grant, resp_valid;
    logic [7:0]   resp_hash, hash_message, hash_result;
    logic         resp_err, busy, hash_enable, hash_reset_n, hash_finished;
    int n_cmp = 0, n_bad = 0;
    int next_d = 3, cur_d = 3, sc = 0;

    hash_engine_arbiter #(.N_REQ(N), .TIMEOUT(64)) dut (
        .clock(clock), .reset(reset), .req(req), .req_msg(req_msg),
        .grant(grant), .resp_valid(resp_valid), .resp_hash(resp_hash),
        .resp_err(resp_err), .busy(busy), .hash_message(hash_message),
        .hash_enable(hash_enable), .hash_reset_n(hash_reset_n),
        .hash_result(hash_result), .hash_finished(hash_finished)
    );

    always #5 clock = ~clock;

    // engine stub: finishes on its cur_d-th enabled cycle after a clear
    always @(posedge clock) sc <= !hash_reset_n ? 0 : hash_enable ? sc + 1 : sc;
    assign hash_finished = hash_enable && (sc == cur_d - 1);
    assign hash_result   = hash_message ^ 8'hA5;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // model: one job is a timeline of d = 1 (clear), 2..L (run), L+1 (response)
    bit         m_act = 0, m_err = 0;
    int         m_w, m_d, m_L, m_D, m_ptr = 0;
    logic [7:0] m_msg, m_hash = 0;
    always @(negedge clock) begin
        if (reset) begin
            m_act = 0; m_ptr = 0; m_hash = 0; m_err = 0;
            chk("rst_grant", grant, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rv", resp_valid, 0);
            chk("rst_hash", resp_hash, 0);
            chk("rst_err", resp_err, 0);
            chk("rst_en", hash_enable, 0);
            chk("rst_rstn", hash_reset_n, 0);
        end else begin
            if (m_act && m_d == m_L + 1) begin
                m_err  = m_D > 64;
                m_hash = m_err ? 8'h00 : m_msg ^ 8'hA5;
            end
            chk("grant", grant, m_act ? (1 << m_w) : 0);
            chk("busy", busy, m_act);
            chk("rstn", hash_reset_n, !(m_act && m_d == 1));
            chk("en", hash_enable, m_act && m_d >= 2 && m_d <= m_L);
            chk("rv", resp_valid, (m_act && m_d == m_L + 1) ? (1 << m_w) : 0);
            chk("hash", resp_hash, m_hash);
            chk("err", resp_err, m_err);
            if (hash_enable) chk("msg", hash_message, m_msg);
            if (m_act) begin
                if (m_d == m_L + 1) begin
                    m_act = 0;
                    m_ptr = (m_w + 1) % N;
                end else m_d++;
            end else if (req != 0) begin
                for (int k = 0; k < N; k++)
                    if (!m_act && req[(m_ptr + k) % N]) begin
                        m_act = 1;
                        m_w   = (m_ptr + k) % N;
                    end
                m_d   = 1;
                m_msg = req_msg[8*m_w +: 8];
                m_D   = next_d;
                cur_d = next_d;
                m_L   = 1 + (m_D < 64 ? m_D : 64);
            end
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output logic [N-1:0] g);
        for (int i = 0; i < 200 && grant == 0; i++) tick(1);
        g = grant;
    endtask

    task automatic next_grant(output logic [N-1:0] g);
        for (int i = 0; i < 200 && grant != 0; i++) tick(1);
        wait_grant(g);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) tick(1);
        chk("idle_bound", busy, 0);
    endtask

    logic [N-1:0] g;
    initial begin
        tick(2);
        #2 reset = 1'b0;
        // single request
        tick(1);
        req = 4'b0001; req_msg = 32'h0000_003C;
        tick(1);
        chk("single_grant", grant, 4'b0001);
        chk("single_rstn", hash_reset_n, 0);
        req = 0;
        tick(4);
        chk("single_rv", resp_valid, 4'b0001);
        chk("single_hash", resp_hash, 8'h99);
        chk("single_err", resp_err, 0);
        tick(1);
        chk("single_busy", busy, 0);
        // request withdrawn mid-job
        req = 4'b1000; req_msg = 32'h5A00_0000;
        tick(2);
        req = 0;
        tick(3);
        chk("wd_rv", resp_valid, 4'b1000);
        chk("wd_hash", resp_hash, 8'hFF);
        tick(1);
        // stalled engine
        next_d = 200;
        req = 4'b0100;
        tick(1);
        req = 0;
        tick(64);
        chk("to_early", resp_valid, 0);
        tick(1);
        chk("to_rv", resp_valid, 4'b0100);
        chk("to_err", resp_err, 1);
        chk("to_hash", resp_hash, 8'h00);
        tick(1);
        next_d = 3;
        // fairness
        req = 4'b0100;
        wait_grant(g);
        chk("fair_a", g, 4'b0100);
        req = 4'b0110;
        next_grant(g);
        chk("fair_b", g, 4'b0010);
        next_grant(g);
        chk("fair_c", g, 4'b0100);
        req = 0;
        wait_idle();
        // async reset in the middle of RUN
        req = 4'b0010;
        tick(3);
        req = 0;
        chk("pre_rst_en", hash_enable, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_en", hash_enable, 0);
        chk("arst_rstn", hash_reset_n, 0);
        req = 4'b1111;
        tick(1);
        #2 reset = 1'b0;
        // all requesting: strict rotation from index 0
        wait_grant(g);
        chk("rr0", g, 4'b0001);
        next_grant(g); chk("rr1", g, 4'b0010);
        next_grant(g); chk("rr2", g, 4'b0100);
        next_grant(g); chk("rr3", g, 4'b1000);
        next_grant(g); chk("rr4", g, 4'b0001);
        req = 0;
        wait_idle();
        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            req     = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
            req_msg = $urandom;
            case ($urandom_range(0, 9))
                0: next_d = 64;
                1: next_d = 65;
                2: next_d = $urandom_range(66, 100);
                3: next_d = 63;
                default: next_d = $urandom_range(1, 6);
            endcase
            tick(1);
        end
        req = 0;
        tick(1);
        wait_idle();
        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
